control_decode_stage: RTL and testbench
=======================================

// Module: control_decode_stage
// PURPOSE
//  Registered successor to the combinational control logic unit. Decodes a full RV32I word
//  into the control bundle, holds it in a valid/ready pipeline register between IF and EX,
//  and inserts one bubble on load-use hazards. Sits between fetch and the register-file/ALU stage.
// PARAMETERS
//  INST_W    32  instruction width; only [31:0] are decoded
//  ALU_OP_W  5   alu_op width; fop_t encoding: ADD=0 .. XORI=15, IMM=16
//  BR_W      3   branch_type width
// PORTS
//  clk                   in   1         clock
//  nrst                  in   1         synchronous reset, active low
//  in_valid              in   1         instruction word valid from fetch
//  in_ready              out  1         stage can accept instruction this cycle
//  instruction           in   INST_W    raw instruction word
//  flush                 in   1         kill held and incoming instruction (taken branch/jump)
//  out_valid             out  1         control bundle valid to EX
//  out_ready             in   1         EX accepts bundle
//  alu_op                out  ALU_OP_W  ALU operation
//  branch_type           out  BR_W      0 none,1 BEQ,2 BNE,3 BLT,4 BGE,5 BLTU,6 BGEU,7 jump
//  reg_write_en, alu_mux_en, store_byte, load_byte, mem_to_reg, write_mem, read_mem,
//  pc_absolute_jump_vec, read_next_pc   out 1 each  datapath controls, same meaning as today
//  rd, rs1, rs2          out  5 each    register indices of held instruction
//  illegal               out  1         held instruction did not decode
//  hazard_stall          out  1         bubble being inserted this cycle
// BEHAVIOUR
//  - Reset (nrst=0 at posedge): state=EMPTY; out_valid=0; every control output, rd/rs1/rs2,
//    illegal, hazard_stall = 0; alu_op=FOP_ADD(0).
//  - Decode is combinational on instruction; result captured on handshake (in_valid&in_ready).
//    Latency: 1 cycle from accept to out_valid.
//  - Opcode map: 0110011 R (funct7[5],funct3 -> ADD/SUB/SLL/SRL/SRA/AND/OR/XOR);
//    0010011 I-ALU (the *I ops, SRAI via funct7[5]); 0000011 LB/LW (read_mem, mem_to_reg,
//    load_byte for funct3=000, alu ADD, alu_mux_en); 0100011 SB/SW (write_mem, store_byte for
//    funct3=000, no reg_write); 1100011 branches (branch_type by funct3, alu SUB);
//    1101111 JAL / 1100111 JALR (branch_type=7, read_next_pc, reg_write; JALR also
//    pc_absolute_jump_vec); 0110111 LUI / 0010111 AUIPC (alu FOP_IMM, alu_mux_en).
//  - Any other opcode/funct combo: illegal=1, all enables 0, alu_op=0; still handed off as valid.
//  - FSM: EMPTY -> FULL on accept. FULL & out_ready & accept -> FULL; FULL & out_ready &
//    !accept -> EMPTY; FULL & !out_ready -> FULL, bundle held stable (no change while
//    out_valid & !out_ready). FULL -> BUBBLE on hazard; BUBBLE -> FULL on next accept.
//  - in_ready = (state!=FULL | out_ready) & !hazard.
//  - Hazard: held bundle has read_mem=1, rd!=0, out_ready=1, and incoming valid word uses rs1
//    or rs2 equal to rd (rs2 only for R/S/B types). Then in_ready=0, hazard_stall=1 for exactly
//    one cycle; next cycle out_valid=0 (bubble), then incoming word accepted.
//  - flush (priority over everything but reset): next cycle state=EMPTY, out_valid=0,
//    incoming word dropped, hazard_stall cleared; in_ready=1 during flush cycle is ignored.
//  - Reset mid-stall or mid-bubble: returns to EMPTY, no bundle emitted.
// CONFIGURATION
//  CLU_SLT_EN defined: SLT/SLTU/SLTI/SLTIU decode to alu_op 17/18/17/18, legal.
//  Not defined: these funct3=010/011 words decode as illegal=1.
// TESTING
//  - Reset: nrst=0 two cycles -> out_valid=0, alu_op=0, in_ready=1 after release.
//  - 0x002081B3 (add x3,x1,x2), out_ready=1 -> next cycle out_valid=1, alu_op=0, reg_write_en=1.
//  - Backpressure: out_ready=0 with 0x40208133 held -> alu_op=2 stable, in_ready=0 until ready.
//  - 0x0000A183 (lw x3,0(x1)) then 0x00318233 (add x4,x3,x3) -> hazard_stall=1 one cycle,
//    one bubble cycle out_valid=0, then add bundle valid.
//  - flush=1 while FULL with in_valid=1 -> next cycle out_valid=0, word not emitted.
//  - 0x0020A1B3 (slt): with CLU_SLT_EN alu_op=17, illegal=0; without, illegal=1.

Source files
------------

// File: rtl/control_decode_stage_if.sv
// Fetch-to-EX handshake bundle for the registered RV32I control decode stage.
// master drives instructions and EX readiness; slave is the decode stage.
interface control_decode_stage_if #(
    parameter int INST_W   = 32,
    parameter int ALU_OP_W = 5,
    parameter int BR_W     = 3
);
    logic                in_valid;
    logic                in_ready;
    logic [INST_W-1:0]   instruction;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [ALU_OP_W-1:0] alu_op;
    logic [BR_W-1:0]     branch_type;
    logic                reg_write_en;
    logic                alu_mux_en;
    logic                store_byte;
    logic                load_byte;
    logic                mem_to_reg;
    logic                write_mem;
    logic                read_mem;
    logic                pc_absolute_jump_vec;
    logic                read_next_pc;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                illegal;
    logic                hazard_stall;

    modport master (
        output in_valid, instruction, flush, out_ready,
        input  in_ready, out_valid, alu_op, branch_type,
        input  reg_write_en, alu_mux_en, store_byte, load_byte,
        input  mem_to_reg, write_mem, read_mem,
        input  pc_absolute_jump_vec, read_next_pc,
        input  rd, rs1, rs2, illegal, hazard_stall
    );

    modport slave (
        input  in_valid, instruction, flush, out_ready,
        output in_ready, out_valid, alu_op, branch_type,
        output reg_write_en, alu_mux_en, store_byte, load_byte,
        output mem_to_reg, write_mem, read_mem,
        output pc_absolute_jump_vec, read_next_pc,
        output rd, rs1, rs2, illegal, hazard_stall
    );
endinterface

// File: rtl/control_decode_stage.sv
// Registered RV32I control decode stage with load-use bubble insertion.
// Optional feature macro: CLU_SLT_EN (legal SLT/SLTU/SLTI/SLTIU decode).
module control_decode_stage #(
    parameter int INST_W   = 32,
    parameter int ALU_OP_W = 5,
    parameter int BR_W     = 3
) (
    input logic                   clk,
    input logic                   nrst,
    control_decode_stage_if.slave bus
);

    // ALU ops come in reg/imm pairs; FOP_SUBI is reserved and never decoded
    localparam logic [ALU_OP_W-1:0] FOP_ADD   = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] FOP_ADDI  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] FOP_SUB   = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] FOP_SLL   = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] FOP_SLLI  = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] FOP_SRL   = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] FOP_SRLI  = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] FOP_SRA   = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] FOP_SRAI  = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] FOP_AND   = ALU_OP_W'(10);
    localparam logic [ALU_OP_W-1:0] FOP_ANDI  = ALU_OP_W'(11);
    localparam logic [ALU_OP_W-1:0] FOP_OR    = ALU_OP_W'(12);
    localparam logic [ALU_OP_W-1:0] FOP_ORI   = ALU_OP_W'(13);
    localparam logic [ALU_OP_W-1:0] FOP_XOR   = ALU_OP_W'(14);
    localparam logic [ALU_OP_W-1:0] FOP_XORI  = ALU_OP_W'(15);
    localparam logic [ALU_OP_W-1:0] FOP_IMM   = ALU_OP_W'(16);
`ifdef CLU_SLT_EN
    localparam logic [ALU_OP_W-1:0] FOP_SLT   = ALU_OP_W'(17);
    localparam logic [ALU_OP_W-1:0] FOP_SLTU  = ALU_OP_W'(18);
`endif

    localparam logic [BR_W-1:0] BR_NONE = BR_W'(0);
    localparam logic [BR_W-1:0] BR_BEQ  = BR_W'(1);
    localparam logic [BR_W-1:0] BR_BNE  = BR_W'(2);
    localparam logic [BR_W-1:0] BR_BLT  = BR_W'(3);
    localparam logic [BR_W-1:0] BR_BGE  = BR_W'(4);
    localparam logic [BR_W-1:0] BR_BLTU = BR_W'(5);
    localparam logic [BR_W-1:0] BR_BGEU = BR_W'(6);
    localparam logic [BR_W-1:0] BR_JUMP = BR_W'(7);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FULL,
        S_BUBBLE
    } state_t;

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic [BR_W-1:0]     br;
        logic                rw;
        logic                mux;
        logic                sb;
        logic                lb;
        logic                m2r;
        logic                wm;
        logic                rm;
        logic                pca;
        logic                np;
        logic                ill;
    } ctrl_t;

    logic [INST_W-1:0] w_raw;
    logic [31:0]       w_ins;
    logic [6:0]        w_opc;
    logic [2:0]        w_f3;
    logic [6:0]        w_f7;
    logic [4:0]        w_rd;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic              w_f7_z;
    logic              w_f7_alt;
    logic              w_is_r;
    logic              w_is_i;
    logic              w_is_ld;
    logic              w_is_st;
    logic              w_is_br;
    logic              w_is_jal;
    logic              w_is_jalr;
    logic              w_is_u;
    ctrl_t             w_dec;
    logic              w_ok;
    logic              w_use1;
    logic              w_use2;
    logic              w_hazard;
    logic              w_in_ready;
    logic              w_accept;

    state_t            r_state;
    ctrl_t             r_ctrl;
    logic [4:0]        r_rd;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;

    assign w_raw     = bus.instruction;
    assign w_ins     = w_raw[31:0];
    assign w_opc     = w_ins[6:0];
    assign w_rd      = w_ins[11:7];
    assign w_f3      = w_ins[14:12];
    assign w_rs1     = w_ins[19:15];
    assign w_rs2     = w_ins[24:20];
    assign w_f7      = w_ins[31:25];
    assign w_f7_z    = (w_f7 == 7'b0000000);
    assign w_f7_alt  = (w_f7 == 7'b0100000);

    assign w_is_r    = (w_opc == 7'b0110011);
    assign w_is_i    = (w_opc == 7'b0010011);
    assign w_is_ld   = (w_opc == 7'b0000011);
    assign w_is_st   = (w_opc == 7'b0100011);
    assign w_is_br   = (w_opc == 7'b1100011);
    assign w_is_jal  = (w_opc == 7'b1101111);
    assign w_is_jalr = (w_opc == 7'b1100111);
    assign w_is_u    = (w_opc == 7'b0110111) | (w_opc == 7'b0010111);

    always_comb begin
        w_dec  = '0;
        w_ok   = 1'b0;
        w_use1 = 1'b0;
        w_use2 = 1'b0;
        unique case (1'b1)
            w_is_r: begin
                w_use1   = 1'b1;
                w_use2   = 1'b1;
                w_dec.rw = 1'b1;
                unique case ({w_f7[5], w_f3})
                    4'b0_000: begin w_dec.alu_op = FOP_ADD; w_ok = w_f7_z;   end
                    4'b1_000: begin w_dec.alu_op = FOP_SUB; w_ok = w_f7_alt; end
                    4'b0_001: begin w_dec.alu_op = FOP_SLL; w_ok = w_f7_z;   end
                    4'b0_101: begin w_dec.alu_op = FOP_SRL; w_ok = w_f7_z;   end
                    4'b1_101: begin w_dec.alu_op = FOP_SRA; w_ok = w_f7_alt; end
                    4'b0_111: begin w_dec.alu_op = FOP_AND; w_ok = w_f7_z;   end
                    4'b0_110: begin w_dec.alu_op = FOP_OR;  w_ok = w_f7_z;   end
                    4'b0_100: begin w_dec.alu_op = FOP_XOR; w_ok = w_f7_z;   end
`ifdef CLU_SLT_EN
                    4'b0_010: begin w_dec.alu_op = FOP_SLT;  w_ok = w_f7_z; end
                    4'b0_011: begin w_dec.alu_op = FOP_SLTU; w_ok = w_f7_z; end
`endif
                    default:  w_ok = 1'b0;
                endcase
            end
            w_is_i: begin
                w_use1    = 1'b1;
                w_dec.rw  = 1'b1;
                w_dec.mux = 1'b1;
                unique case (w_f3)
                    3'b000: begin w_dec.alu_op = FOP_ADDI; w_ok = 1'b1;   end
                    3'b001: begin w_dec.alu_op = FOP_SLLI; w_ok = w_f7_z; end
                    3'b101: begin
                        w_dec.alu_op = w_f7[5] ? FOP_SRAI : FOP_SRLI;
                        w_ok         = w_f7_z | w_f7_alt;
                    end
                    3'b111: begin w_dec.alu_op = FOP_ANDI; w_ok = 1'b1; end
                    3'b110: begin w_dec.alu_op = FOP_ORI;  w_ok = 1'b1; end
                    3'b100: begin w_dec.alu_op = FOP_XORI; w_ok = 1'b1; end
`ifdef CLU_SLT_EN
                    3'b010: begin w_dec.alu_op = FOP_SLT;  w_ok = 1'b1; end
                    3'b011: begin w_dec.alu_op = FOP_SLTU; w_ok = 1'b1; end
`endif
                    default: w_ok = 1'b0;
                endcase
            end
            w_is_ld: begin
                w_use1       = 1'b1;
                w_ok         = (w_f3 == 3'b000) | (w_f3 == 3'b010);
                w_dec.alu_op = FOP_ADD;
                w_dec.mux    = 1'b1;
                w_dec.rw     = 1'b1;
                w_dec.rm     = 1'b1;
                w_dec.m2r    = 1'b1;
                w_dec.lb     = (w_f3 == 3'b000);
            end
            w_is_st: begin
                w_use1       = 1'b1;
                w_use2       = 1'b1;
                w_ok         = (w_f3 == 3'b000) | (w_f3 == 3'b010);
                w_dec.alu_op = FOP_ADD;
                w_dec.mux    = 1'b1;
                w_dec.wm     = 1'b1;
                w_dec.sb     = (w_f3 == 3'b000);
            end
            w_is_br: begin
                w_use1       = 1'b1;
                w_use2       = 1'b1;
                w_ok         = 1'b1;
                w_dec.alu_op = FOP_SUB;
                unique case (w_f3)
                    3'b000:  w_dec.br = BR_BEQ;
                    3'b001:  w_dec.br = BR_BNE;
                    3'b100:  w_dec.br = BR_BLT;
                    3'b101:  w_dec.br = BR_BGE;
                    3'b110:  w_dec.br = BR_BLTU;
                    3'b111:  w_dec.br = BR_BGEU;
                    default: w_ok     = 1'b0;
                endcase
            end
            w_is_jal: begin
                w_ok     = 1'b1;
                w_dec.br = BR_JUMP;
                w_dec.np = 1'b1;
                w_dec.rw = 1'b1;
            end
            w_is_jalr: begin
                w_use1    = 1'b1;
                w_ok      = (w_f3 == 3'b000);
                w_dec.br  = BR_JUMP;
                w_dec.np  = 1'b1;
                w_dec.rw  = 1'b1;
                w_dec.pca = 1'b1;
                w_dec.mux = 1'b1;
            end
            w_is_u: begin
                w_ok         = 1'b1;
                w_dec.alu_op = FOP_IMM;
                w_dec.mux    = 1'b1;
                w_dec.rw     = 1'b1;
            end
            default: w_ok = 1'b0;
        endcase
        if (!w_ok) begin
            w_dec     = '0;
            w_dec.br  = BR_NONE;
            w_dec.ill = 1'b1;
        end
    end

    // Held load retires this cycle while its consumer waits one slot
    assign w_hazard = (r_state == S_FULL) & r_ctrl.rm & (r_rd != 5'd0)
                    & bus.out_ready & bus.in_valid & ~bus.flush
                    & ((w_use1 & (w_rs1 == r_rd))
                     | (w_use2 & (w_rs2 == r_rd)));

    assign w_in_ready = ((r_state != S_FULL) | bus.out_ready) & ~w_hazard;
    assign w_accept   = bus.in_valid & w_in_ready;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= S_EMPTY;
            r_ctrl  <= '0;
            r_rd    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
        end else if (bus.flush) begin
            r_state <= S_EMPTY;
        end else begin
            unique case (r_state)
                S_FULL: begin
                    if (w_hazard)
                        r_state <= S_BUBBLE;
                    else if (bus.out_ready)
                        r_state <= w_accept ? S_FULL : S_EMPTY;
                end
                default: begin
                    if (w_accept)
                        r_state <= S_FULL;
                end
            endcase
            if (w_accept) begin
                r_ctrl <= w_dec;
                r_rd   <= w_rd;
                r_rs1  <= w_rs1;
                r_rs2  <= w_rs2;
            end
        end
    end

    assign bus.in_ready             = w_in_ready;
    assign bus.out_valid            = (r_state == S_FULL);
    assign bus.hazard_stall         = w_hazard;
    assign bus.alu_op               = r_ctrl.alu_op;
    assign bus.branch_type          = r_ctrl.br;
    assign bus.reg_write_en         = r_ctrl.rw;
    assign bus.alu_mux_en           = r_ctrl.mux;
    assign bus.store_byte           = r_ctrl.sb;
    assign bus.load_byte            = r_ctrl.lb;
    assign bus.mem_to_reg           = r_ctrl.m2r;
    assign bus.write_mem            = r_ctrl.wm;
    assign bus.read_mem             = r_ctrl.rm;
    assign bus.pc_absolute_jump_vec = r_ctrl.pca;
    assign bus.read_next_pc         = r_ctrl.np;
    assign bus.illegal              = r_ctrl.ill;
    assign bus.rd                   = r_rd;
    assign bus.rs1                  = r_rs1;
    assign bus.rs2                  = r_rs2;

endmodule

// File: tb/tb_control_decode_stage.sv
// Directed scoreboard bench for control_decode_stage.
// Define CLU_SLT_EN to check the SLT-enabled decode.
module tb_control_decode_stage;

    typedef logic [22:0] obs_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        obs_t        o;
    } vec_t;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    control_decode_stage_if bus ();

    control_decode_stage dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t q[$];
    vec_t cur;
    bit   acc;

    // expected = {alu_op, branch_type, flags, illegal, rd}
    // flags = {rw, mux, sb, lb, m2r, wm, rm, pca, np}
    function automatic vec_t mk(string n, logic [31:0] ins,
                                logic [4:0] alu, logic [2:0] br,
                                logic [8:0] f, logic ill, logic [4:0] rd);
        vec_t v;
        v.name = n;
        v.ins  = ins;
        v.o    = {alu, br, f, ill, rd};
        return v;
    endfunction

    function automatic obs_t observe();
        return {bus.alu_op, bus.branch_type,
                bus.reg_write_en, bus.alu_mux_en, bus.store_byte,
                bus.load_byte, bus.mem_to_reg, bus.write_mem,
                bus.read_mem, bus.pc_absolute_jump_vec,
                bus.read_next_pc, bus.illegal, bus.rd};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        vec_t e;
        acc = 1'b0;
        #1;
        if (!nrst) begin
            q.delete();
        end else if (bus.flush) begin
            q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 64'(bus.out_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk(e.name, 64'(observe()), 64'(e.o));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(cur);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(vec_t v);
        bus.in_valid    = 1'b1;
        bus.instruction = v.ins;
        cur             = v;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (acc) break;
        end
        chk({"accept_", v.name}, 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
    endtask

    vec_t v_add, v_sub, v_lw3, v_add4, v_lb, v_sb, v_beq, v_bgeu;
    vec_t v_jal, v_jalr, v_lui, v_srai, v_xori, v_bad, v_badbr;
    vec_t v_slt, v_lw0, v_add0, v_addi;
    vec_t stream[$];

    initial begin
        v_add   = mk("add",   32'h002081B3, 5'd0,  3'd0, 9'b100000000, 1'b0, 5'd3);
        v_sub   = mk("sub",   32'h40208133, 5'd2,  3'd0, 9'b100000000, 1'b0, 5'd2);
        v_lw3   = mk("lw_x3", 32'h0000A183, 5'd0,  3'd0, 9'b110010100, 1'b0, 5'd3);
        v_add4  = mk("add_x4",32'h00318233, 5'd0,  3'd0, 9'b100000000, 1'b0, 5'd4);
        v_lb    = mk("lb",    32'h00410283, 5'd0,  3'd0, 9'b110110100, 1'b0, 5'd5);
        v_sb    = mk("sb",    32'h00208023, 5'd0,  3'd0, 9'b011001000, 1'b0, 5'd0);
        v_beq   = mk("beq",   32'h00208063, 5'd2,  3'd1, 9'b000000000, 1'b0, 5'd0);
        v_bgeu  = mk("bgeu",  32'h0020F063, 5'd2,  3'd6, 9'b000000000, 1'b0, 5'd0);
        v_jal   = mk("jal",   32'h000000EF, 5'd0,  3'd7, 9'b100000001, 1'b0, 5'd1);
        v_jalr  = mk("jalr",  32'h000100E7, 5'd0,  3'd7, 9'b110000011, 1'b0, 5'd1);
        v_lui   = mk("lui",   32'h123452B7, 5'd16, 3'd0, 9'b110000000, 1'b0, 5'd5);
        v_srai  = mk("srai",  32'h4030D313, 5'd9,  3'd0, 9'b110000000, 1'b0, 5'd6);
        v_xori  = mk("xori",  32'hFFF0C393, 5'd15, 3'd0, 9'b110000000, 1'b0, 5'd7);
        v_bad   = mk("badop", 32'h0000007F, 5'd0,  3'd0, 9'b000000000, 1'b1, 5'd0);
        v_badbr = mk("badbr", 32'h0020A063, 5'd0,  3'd0, 9'b000000000, 1'b1, 5'd0);
`ifdef CLU_SLT_EN
        v_slt   = mk("slt",   32'h0020A1B3, 5'd17, 3'd0, 9'b100000000, 1'b0, 5'd3);
`else
        v_slt   = mk("slt",   32'h0020A1B3, 5'd0,  3'd0, 9'b000000000, 1'b1, 5'd3);
`endif
        v_lw0   = mk("lw_x0", 32'h0000A003, 5'd0,  3'd0, 9'b110010100, 1'b0, 5'd0);
        v_add0  = mk("add_x0",32'h00000233, 5'd0,  3'd0, 9'b100000000, 1'b0, 5'd4);
        v_addi  = mk("addi",  32'h00308213, 5'd1,  3'd0, 9'b110000000, 1'b0, 5'd4);

        nrst            = 1'b0;
        bus.in_valid    = 1'b0;
        bus.instruction = 32'h0;
        bus.flush       = 1'b0;
        bus.out_ready   = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid),    64'd0);
        chk("rst_alu_op",    64'(bus.alu_op),       64'd0);
        chk("rst_hazard",    64'(bus.hazard_stall), 64'd0);
        chk("rst_bundle",    64'(observe()),        64'd0);
        nrst = 1'b1;
        #1;
        chk("rst_in_ready",  64'(bus.in_ready),     64'd1);

        stream = '{v_add, v_srai, v_xori, v_lb, v_sb, v_beq, v_bgeu,
                   v_jal, v_jalr, v_lui, v_slt, v_bad, v_badbr};
        foreach (stream[i]) send(stream[i]);
        idle(2);

        // backpressure: held SUB must not move while EX stalls
        bus.out_ready = 1'b0;
        send(v_sub);
        bus.in_valid    = 1'b1;
        bus.instruction = v_xori.ins;
        cur             = v_xori;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready",  64'(bus.in_ready),  64'd0);
            chk("bp_alu_op",    64'(bus.alu_op),    64'd2);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            cycle();
        end
        bus.out_ready = 1'b1;
        send(v_xori);
        idle(2);

        // load-use hazard: one stall cycle then one bubble
        send(v_lw3);
        bus.in_valid    = 1'b1;
        bus.instruction = v_add4.ins;
        cur             = v_add4;
        #1;
        chk("hz_stall",      64'(bus.hazard_stall), 64'd1);
        chk("hz_in_ready",   64'(bus.in_ready),     64'd0);
        cycle();
        #1;
        chk("bub_out_valid", 64'(bus.out_valid),    64'd0);
        chk("bub_stall",     64'(bus.hazard_stall), 64'd0);
        chk("bub_in_ready",  64'(bus.in_ready),     64'd1);
        cycle();
        bus.in_valid = 1'b0;
        #1;
        chk("post_bub_valid", 64'(bus.out_valid),   64'd1);
        idle(2);

        // no hazard for rd=x0 or for an I-type whose imm aliases rs2
        send(v_lw0);
        bus.in_valid    = 1'b1;
        bus.instruction = v_add0.ins;
        #1;
        chk("x0_no_hazard",  64'(bus.hazard_stall), 64'd0);
        send(v_add0);
        send(v_lw3);
        bus.in_valid    = 1'b1;
        bus.instruction = v_addi.ins;
        #1;
        chk("i_rs2_no_hazard", 64'(bus.hazard_stall), 64'd0);
        chk("i_rs2_in_ready",  64'(bus.in_ready),     64'd1);
        send(v_addi);
        idle(2);

        // flush kills held and incoming words
        bus.out_ready = 1'b0;
        send(v_add);
        bus.flush       = 1'b1;
        bus.in_valid    = 1'b1;
        bus.instruction = v_lui.ins;
        cur             = v_lui;
        cycle();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        idle(3);

        // flush overrides a pending hazard
        send(v_lw3);
        bus.flush       = 1'b1;
        bus.in_valid    = 1'b1;
        bus.instruction = v_add4.ins;
        cur             = v_add4;
        #1;
        chk("flush_hz_stall", 64'(bus.hazard_stall), 64'd0);
        cycle();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("flush_hz_valid", 64'(bus.out_valid), 64'd0);
        idle(2);

        // reset during the bubble emits nothing
        send(v_lw3);
        bus.in_valid    = 1'b1;
        bus.instruction = v_add4.ins;
        cur             = v_add4;
        cycle();
        nrst = 1'b0;
        cycle();
        nrst         = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_bub_valid", 64'(bus.out_valid), 64'd0);
        idle(3);

        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
